// File: rtl/addsub_pkg.sv
// Shared constants for the add/subtract accumulator: command codes and FSM states.
package addsub_pkg;

    // Command codes carried on the op input.
    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    // Accumulator control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/addersubtractor.sv
// Ripple-style adder/subtractor: S = A + (B ^ {M}) + M, carry is the bit-WIDTH carry-out.
module addersubtractor #(
    parameter int WIDTH = 4
) (
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             carry
);

    logic [WIDTH:0] sum_w;

    // Subtraction is addition of the inverted operand plus one through the carry-in.
    assign sum_w = {1'b0, A} + {1'b0, B ^ {WIDTH{M}}} + {{WIDTH{1'b0}}, M};
    assign S     = sum_w[WIDTH-1:0];
    assign carry = sum_w[WIDTH];

endmodule

// File: rtl/addsub_accumulator.sv
// Command-driven accumulator: accepts one command in IDLE, computes in EXEC,
// presents the result in HOLD until downstream takes it.
//
// Handshake: a command transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE and out_valid only in HOLD, so at most one command is in flight.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             m_w;
    logic [WIDTH-1:0] beff_w;
    logic [WIDTH-1:0] sum_w;
    logic             cout_w;

    // SUB selects the inverting path of the shared adder.
    assign m_w    = (op_q == OP_SUB);
    assign beff_w = b_q ^ {WIDTH{m_w}};

    addersubtractor #(.WIDTH(WIDTH)) u_addsub (
        .M     (m_w),
        .A     (acc_q),
        .B     (b_q),
        .S     (sum_w),
        .carry (cout_w)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op;
                    b_d     = B;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        acc_d   = sum_w;
                        carry_d = cout_w;
                        ovf_d   = (acc_q[MSB] ~^ beff_w[MSB]) & (acc_q[MSB] ^ sum_w[MSB]);
                    end
                    OP_LOAD: begin
                        acc_d   = b_q;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                    end
                    OP_CLEAR: begin
                        acc_d   = '0;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                    end
                endcase
                zero_d  = (acc_d == '0);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign S           = acc_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Testbench for addsub_accumulator (WIDTH=4): directed vectors plus randomized
// commands checked against an arithmetic reference model.
module tb_addsub_accumulator;
  import addsub_pkg::*;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference accumulator value and expected results {S, carry, overflow, zero}.
  int           m_acc = 0;
  logic [W+2:0] exp_q[$];

  addsub_accumulator #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .S           (S),
    .carry       (carry),
    .zero        (zero),
    .overflow    (overflow),
    .dbg_state_o (dbg_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Signed view of a W-bit unsigned value.
  function automatic int to_signed(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Reference model: integer arithmetic on the command rules.
  function automatic void model_cmd(input logic [1:0] c_op, input logic [W-1:0] c_b);
    int a, b, full, sr, s;
    bit c, v;
    a = m_acc;
    b = int'(c_b);
    s = 0; c = 1'b0; v = 1'b0;
    case (c_op)
      OP_ADD: begin
        full = a + b;
        s    = full % MOD;
        c    = (full >= MOD);
        sr   = to_signed(a) + to_signed(b);
        v    = (sr > HALF - 1) || (sr < -HALF);
      end
      OP_SUB: begin
        s  = (a - b + MOD) % MOD;
        c  = (a >= b);
        sr = to_signed(a) - to_signed(b);
        v  = (sr > HALF - 1) || (sr < -HALF);
      end
      OP_LOAD:  s = b;
      default:  s = 0;
    endcase
    m_acc = s;
    exp_q.push_back({W'(s), c, v, (s == 0)});
  endfunction

  // One full command: accept, EXEC, HOLD for 'hold' extra cycles (with optional
  // in_valid noise), then release. Returns the observed {S, carry, overflow, zero}.
  task automatic run_cmd(input logic [1:0] c_op, input logic [W-1:0] c_b,
                         input int hold, input bit noise, output logic [W+2:0] obs);
    logic [W+2:0] exp_v;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL idle_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      n_errors++;
    end
    in_valid = 1'b1;
    op       = c_op;
    B        = c_b;
    model_cmd(c_op, c_b);
    @(negedge clk);
    // Accept edge has passed; scramble inputs, the command must already be latched.
    in_valid = 1'b0;
    op       = 2'($urandom_range(0, 3));
    B        = W'($urandom_range(0, MOD - 1));
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL exec_handshake: out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
      n_errors++;
    end
    @(negedge clk);
    obs = {S, carry, overflow, zero};
    if (exp_q.size() == 0) begin
      exp_v = '0;
      $display("FAIL scoreboard_empty: no expected result queued");
      n_errors++;
    end else begin
      exp_v = exp_q.pop_front();
    end
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL hold_latency: out_valid=%b in_ready=%b two edges after accept, want 1 0",
               out_valid, in_ready);
      n_errors++;
    end
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL result op=%0d b=%0d: got S=%0d c=%b v=%b z=%b, want S=%0d c=%b v=%b z=%b",
               c_op, c_b, obs[W+2:3], obs[2], obs[1], obs[0],
               exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
      n_errors++;
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = noise;
      op       = 2'($urandom_range(0, 3));
      B        = W'($urandom_range(0, MOD - 1));
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {S, carry, overflow, zero} !== exp_v) begin
        $display("FAIL hold_stable cycle %0d: ov=%b ir=%b S=%0d c=%b v=%b z=%b, want 1 0 %0d %b %b %b",
                 k, out_valid, in_ready, S, carry, overflow, zero,
                 exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
        n_errors++;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      n_errors++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = OP_ADD;
    B         = '0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    m_acc = 0;
    n_checks++;
    if (S !== '0 || carry !== 1'b0 || overflow !== 1'b0 || zero !== 1'b1 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_state: S=%0d c=%b v=%b z=%b ov=%b ir=%b, want 0 0 0 1 0 1",
               S, carry, overflow, zero, out_valid, in_ready);
      n_errors++;
    end
  endtask

  task automatic test_directed();
    logic [W+2:0] obs;
    // LOAD 0101, ADD 1001 -> 1110
    run_cmd(OP_LOAD, 4'b0101, 0, 1'b0, obs);
    run_cmd(OP_ADD, 4'b1001, 0, 1'b0, obs);
    n_checks++;
    if (obs !== {4'b1110, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL vec_add: got %b, want 1110_000", obs);
      n_errors++;
    end
    // LOAD 0100, SUB 1011 -> 1001 with borrow and overflow
    run_cmd(OP_LOAD, 4'b0100, 0, 1'b0, obs);
    run_cmd(OP_SUB, 4'b1011, 0, 1'b0, obs);
    n_checks++;
    if (obs !== {4'b1001, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL vec_sub_ovf: got %b, want 1001_010", obs);
      n_errors++;
    end
    // LOAD 1111, ADD 0001 -> wrap to 0000
    run_cmd(OP_LOAD, 4'b1111, 0, 1'b0, obs);
    run_cmd(OP_ADD, 4'b0001, 0, 1'b0, obs);
    n_checks++;
    if (obs !== {4'b0000, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL vec_wrap: got %b, want 0000_101", obs);
      n_errors++;
    end
    // LOAD 1000, SUB 1000 -> 0 with carry, then CLEAR
    run_cmd(OP_LOAD, 4'b1000, 0, 1'b0, obs);
    run_cmd(OP_SUB, 4'b1000, 0, 1'b0, obs);
    n_checks++;
    if (obs !== {4'b0000, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL vec_sub_equal: got %b, want 0000_101", obs);
      n_errors++;
    end
    run_cmd(OP_CLEAR, 4'b1010, 0, 1'b0, obs);
    n_checks++;
    if (obs !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL vec_clear: got %b, want 0000_001", obs);
      n_errors++;
    end
  endtask

  task automatic test_hold_stall();
    logic [W+2:0] obs;
    run_cmd(OP_LOAD, 4'b0011, 0, 1'b0, obs);
    // Stall 3 cycles with in_valid pulses that must be dropped.
    run_cmd(OP_ADD, 4'b0110, 3, 1'b1, obs);
    // The accumulator must show no trace of the ignored pulses.
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || S !== W'(m_acc)) begin
        $display("FAIL stall_no_queue: out_valid=%b S=%0d, want 0 %0d", out_valid, S, m_acc);
        n_errors++;
      end
    end
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_LOAD;
    B        = 4'b0111;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_acc = 0;
    n_checks++;
    if (S !== '0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        carry !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL reset_exec: S=%0d z=%b ov=%b ir=%b c=%b v=%b, want 0 1 0 1 0 0",
               S, zero, out_valid, in_ready, carry, overflow);
      n_errors++;
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL reset_exec_no_output: out_valid=%b, want 0", out_valid);
        n_errors++;
      end
    end
  endtask

  task automatic test_reset_in_hold();
    logic [W+2:0] obs;
    run_cmd(OP_LOAD, 4'b1101, 0, 1'b0, obs);
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_ADD;
    B        = 4'b0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_acc = 0;
    n_checks++;
    if (S !== '0 || zero !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_hold: S=%0d z=%b ov=%b ir=%b, want 0 1 0 1", S, zero, out_valid, in_ready);
      n_errors++;
    end
  endtask

  task automatic test_random();
    logic [W+2:0] obs;
    for (int i = 0; i < 60; i++) begin
      run_cmd(2'($urandom_range(0, 3)), W'($urandom_range(0, MOD - 1)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), obs);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_stall();
    test_reset_in_exec();
    test_random();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand, accumulator and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a command this cycle.
REQ-006 The block SHALL have port op, input, 2 bits: the command code (ADD=00, SUB=01, LOAD=10, CLEAR=11).
REQ-007 The block SHALL have port B, input, WIDTH bits: the command operand.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port S, output, WIDTH bits: the accumulator value after the command.
REQ-011 The block SHALL have port carry, output, 1 bit: the carry-out of the operation.
REQ-012 The block SHALL have port zero, output, 1 bit: set when S equals 0.
REQ-013 The block SHALL have port overflow, output, 1 bit: two's-complement overflow of the operation.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and HOLD.
REQ-015 In IDLE, in_ready SHALL be 1, and an edge with in_valid=1 SHALL latch op and B and move the FSM to EXEC.
REQ-016 EXEC SHALL last exactly one cycle with in_ready=0, and its closing edge SHALL register the accumulator and all flags and move the FSM to HOLD.
REQ-017 In HOLD, out_valid SHALL be 1 and in_ready 0, and an edge with out_ready=1 SHALL return the FSM to IDLE.
REQ-018 Latency SHALL be: out_valid rises 2 edges after the accepting edge, and at most one command is in flight.
REQ-019 ADD SHALL compute acc+B with M=0; SUB SHALL compute acc+~B+1 with M=1.
REQ-020 For ADD and SUB, carry SHALL be the carry-out of bit WIDTH-1, so for SUB carry=1 means no borrow (acc>=B unsigned).
REQ-021 overflow SHALL equal (acc[MSB] ~^ Beff[MSB]) & (acc[MSB] ^ sum[MSB]), where Beff is B^{WIDTH{M}}.
REQ-022 LOAD SHALL set acc=B with carry=0 and overflow=0.
REQ-023 CLEAR SHALL set acc=0 with carry=0, overflow=0 and zero=1.
REQ-024 Sums SHALL wrap modulo 2^WIDTH, with the excess held only in carry.
REQ-025 S, carry, zero and overflow SHALL hold stable throughout HOLD regardless of in_valid, op or B.
REQ-026 The accumulator SHALL persist across commands and change only on an EXEC edge or on reset.
REQ-027 in_valid SHALL be ignored outside IDLE, with no command queuing.

Reset
REQ-028 On an edge with rst=1, the FSM SHALL go to IDLE and acc, S, carry and overflow SHALL be 0.
REQ-029 After reset, zero SHALL be 1, out_valid 0 and in_ready 1 from the first cycle after the reset edge.
REQ-030 rst SHALL take priority over all other inputs in every state, and a command in EXEC or HOLD SHALL be discarded without output.

Structure
REQ-031 The op codes ADD, SUB, LOAD, CLEAR and the state encodings SHALL be constants in shared package addsub_pkg.
REQ-032 The arithmetic SHALL use one instance of the existing addersubtractor sub-module, port order (M, A, B, S, carry), with A driven by acc.
REQ-033 The FSM, operand register and flag registers SHALL be local to addsub_accumulator.

Verification (WIDTH=4)
REQ-034 The bench SHALL check: LOAD 0101 then ADD 1001 -> S=1110, carry=0, overflow=0, zero=0, out_valid rising 2 edges after each accept.
REQ-035 The bench SHALL check: LOAD 0100 then SUB 1011 -> S=1001, carry=0 (borrow), overflow=1.
REQ-036 The bench SHALL check: LOAD 1111 then ADD 0001 -> S=0000, carry=1, zero=1, overflow=0 (wrap).
REQ-037 The bench SHALL check: with out_ready held at 0 for 3 cycles in HOLD -> S and the flags stay constant, in_ready=0, and a new in_valid pulse is ignored.
REQ-038 The bench SHALL check: rst asserted in EXEC after LOAD 0111 -> next cycle S=0, zero=1, out_valid=0, in_ready=1, with no result emitted.
REQ-039 The bench SHALL check: LOAD 1000 then SUB 1000 then CLEAR -> S=0000, carry=1, zero=1 for SUB, then CLEAR gives S=0, carry=0.
